mul_pipe: RTL and testbench
===========================

Name: mul_pipe

Overview:
Pipelined RV32M multiply unit wrapping the team's combinational `wall_tree` multiplier. It accepts MUL/MULH/MULHSU/MULHU requests from the execute stage over a valid/ready handshake. It converts operands to unsigned magnitudes, registers the tree output, applies sign correction and returns the selected 32-bit word with its destination tag. Throughput is one op per cycle with fixed 3-cycle latency, backpressure, and flush on pipeline redirect.

Parameters:
TAG_W, 5, width of destination-register tag carried alongside each op

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
flush  input  1  kill all in-flight ops; request in same cycle is not accepted
req_valid  input  1  request present
req_ready  output  1  unit can accept this cycle
req_op  input  2  funct3[1:0]: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
req_rs1  input  32  operand a
req_rs2  input  32  operand b
req_rd  input  TAG_W  destination tag
resp_valid  output  1  result present
resp_ready  input  1  consumer takes result
resp_data  output  32  selected result word
resp_rd  output  TAG_W  tag of result

Behaviour:
- Clock/reset: one clock `clk`; `rst` is synchronous, active-high.
- Reset: all stage valid bits = 0; resp_valid = 0, resp_data = 0, resp_rd = 0. Reset mid-operation discards all in-flight ops; no response follows.
- Pipeline:
  - S1 registers magnitudes, negate flag, hi/lo select, tag.
  - S2 registers the 64-bit `wall_tree` product magnitude plus flags.
  - S3 is the output register holding resp_*.
- Advance enable: adv = !(s3_valid && !resp_ready). When adv = 0, every stage holds (global stall; bubbles are not collapsed).
- Handshake:
  - req_ready = adv && !flush.
  - Accept = req_valid && req_ready.
  - Accepted in cycle T with no stall: resp_valid = 1 in cycle T+3.
  - Response is consumed on resp_valid && resp_ready.
  - resp_data and resp_rd stay stable while resp_valid && !resp_ready.
  - Ops retire in order, with no loss and no duplication.
- Flush: synchronous; clears S1/S2/S3 valid bits at the edge, including a result currently held at the output. It has priority over accept and advance. Data registers may keep stale values.
- Signedness:
  - a is signed for op 01 and 10.
  - b is signed for op 01 only.
  - a_neg = a signed && rs1[31]; b_neg = b signed && rs2[31].
  - mag_a = a_neg ? (~rs1 + 1) : rs1, taken as a 32-bit unsigned value. 0x80000000 yields magnitude 0x80000000; this is correct.
  - mag_b is derived the same way.
  - neg = a_neg ^ b_neg.
- Tree usage: `wall_tree` is instantiated with op1sign = op2sign = 0 and is fed mag_a/mag_b from S1. All sign handling is done in this block.
- S2 to S3: prod = neg ? (~mag + 1) : mag, in 64-bit two's complement. A zero product stays zero.
  - op 00: resp_data = prod[31:0].
  - op 01, 10, 11: resp_data = prod[63:32].
- Simultaneous events:
  - rst has priority over flush.
  - flush has priority over accept/advance.
  - A response consumed in the same cycle as a new accept is legal; the pipeline advances.
- req_* inputs are ignored when not accepted. X on req_rs* with req_valid = 0 must not propagate to resp_valid.

Test Plan:
- MUL rs1=7, rs2=6, rd=3, resp_ready=1, accept in T -> T+3: resp_valid=1, resp_data=0x0000002A, resp_rd=3.
- rs1=rs2=0xFFFFFFFF with each op: MUL -> 0x00000001; MULH -> 0x00000000; MULHSU -> 0xFFFFFFFF; MULHU -> 0xFFFFFFFE.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MUL 0x80000000 x 0x00000002 -> 0x00000000; MULH 0x80000000 x 0x00000001 -> 0xFFFFFFFF.
- Four back-to-back MULs (rd 1..4), resp_ready low cycles T+3..T+5 -> req_ready=0 while stalled; rd 1..4 each delivered exactly once, in order, with data held stable during the stall.
- Two ops in flight, flush pulsed one cycle -> no resp_valid for either. A new MUL 3x5 accepted the next cycle -> 0x0000000F three cycles later.
- rst asserted with three ops in flight and resp_valid=1 -> next cycle resp_valid=0, resp_data=0, req_ready=1 after rst deasserts; no stale response appears.

Source files
------------

// File: rtl/mul_pipe.sv
// mul_pipe: three-stage RV32M multiply unit (MUL/MULH/MULHSU/MULHU).
// Operands are reduced to unsigned magnitudes, multiplied by the shared
// wall_tree, and the sign is re-applied before selecting the result word.
`timescale 1ns/1ps

// wall_tree: combinational 32x32 -> 64 multiplier with per-operand sign control.
module wall_tree (
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic        op1sign,
  input  logic        op2sign,
  output logic [63:0] product
);
  logic signed [63:0] op1_ext;
  logic signed [63:0] op2_ext;

  // Extend each operand according to its sign control, then multiply modulo 2^64.
  always_comb begin
    op1_ext = {{32{op1sign & op1[31]}}, op1};
    op2_ext = {{32{op2sign & op2[31]}}, op2};
    product = op1_ext * op2_ext;
  end
endmodule

module mul_pipe #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [31:0]      req_rs1,
  input  logic [31:0]      req_rs2,
  input  logic [TAG_W-1:0] req_rd,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_rd
);
  localparam int DATA_W = 32;

  // Two's-complement magnitude of a 32-bit operand; 0x80000000 maps to itself.
  function automatic logic [DATA_W-1:0] mag32(input logic [DATA_W-1:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  // Re-apply the result sign to a 64-bit unsigned product magnitude.
  function automatic logic signed [2*DATA_W-1:0] apply_sign64(input logic [2*DATA_W-1:0] m,
                                                              input logic neg);
    return neg ? $signed(~m + 64'd1) : $signed(m);
  endfunction

  logic adv;
  logic accept;

  logic              a_neg_d;
  logic              b_neg_d;
  logic [DATA_W-1:0] mag_a_d;
  logic [DATA_W-1:0] mag_b_d;

  logic              vld_p1_q;
  logic [DATA_W-1:0] mag_a_p1_q;
  logic [DATA_W-1:0] mag_b_p1_q;
  logic              neg_p1_q;
  logic              hi_p1_q;
  logic [TAG_W-1:0]  rd_p1_q;

  logic [2*DATA_W-1:0] tree_prod;

  logic                vld_p2_q;
  logic [2*DATA_W-1:0] prod_p2_q;
  logic                neg_p2_q;
  logic                hi_p2_q;
  logic [TAG_W-1:0]    rd_p2_q;

  logic signed [2*DATA_W-1:0] sprod_d;
  logic        [DATA_W-1:0]   data_d;

  logic              vld_p3_q;
  logic [DATA_W-1:0] data_p3_q;
  logic [TAG_W-1:0]  rd_p3_q;

  // Global stall when the output holds an unconsumed result; flush blocks new accepts.
  always_comb begin
    adv       = !(vld_p3_q && !resp_ready);
    req_ready = adv && !flush;
    accept    = req_valid && req_ready;
  end

  // Operand decode: MULH treats both signed, MULHSU only rs1, MUL/MULHU neither.
  always_comb begin
    a_neg_d = ((req_op == 2'b01) || (req_op == 2'b10)) && req_rs1[31];
    b_neg_d = (req_op == 2'b01) && req_rs2[31];
    mag_a_d = mag32(req_rs1, a_neg_d);
    mag_b_d = mag32(req_rs2, b_neg_d);
  end

  // Stage valid bits: reset beats flush, flush beats advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
    end else if (flush) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
    end else if (adv) begin
      vld_p1_q <= accept;
      vld_p2_q <= vld_p1_q;
      vld_p3_q <= vld_p2_q;
    end
  end

  // ---- S1: magnitudes, sign and word select captured on accept ----
  always_ff @(posedge clk) begin
    if (accept) begin
      mag_a_p1_q <= mag_a_d;
      mag_b_p1_q <= mag_b_d;
      neg_p1_q   <= a_neg_d ^ b_neg_d;
      hi_p1_q    <= (req_op != 2'b00);
      rd_p1_q    <= req_rd;
    end
  end

  wall_tree u_tree (
    .op1     (mag_a_p1_q),
    .op2     (mag_b_p1_q),
    .op1sign (1'b0),
    .op2sign (1'b0),
    .product (tree_prod)
  );

  // ---- S2: unsigned product magnitude plus flags ----
  always_ff @(posedge clk) begin
    if (adv && vld_p1_q) begin
      prod_p2_q <= tree_prod;
      neg_p2_q  <= neg_p1_q;
      hi_p2_q   <= hi_p1_q;
      rd_p2_q   <= rd_p1_q;
    end
  end

  // Sign correction and high/low word selection feeding the output register.
  always_comb begin
    sprod_d = apply_sign64(prod_p2_q, neg_p2_q);
    data_d  = hi_p2_q ? sprod_d[2*DATA_W-1:DATA_W] : sprod_d[DATA_W-1:0];
  end

  // ---- S3: output register, held while the consumer stalls ----
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p3_q <= '0;
      rd_p3_q   <= '0;
    end else if (adv && vld_p2_q) begin
      data_p3_q <= data_d;
      rd_p3_q   <= rd_p2_q;
    end
  end

  assign resp_valid = vld_p3_q;
  assign resp_data  = data_p3_q;
  assign resp_rd    = rd_p3_q;
endmodule

// File: tb/tb_mul_pipe.sv
// tb_mul_pipe: directed and randomized checks of mul_pipe against a
// plain-arithmetic RV32M reference model with an in-order scoreboard.
`timescale 1ns/1ps

module tb_mul_pipe;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [31:0]      req_rs1;
  logic [31:0]      req_rs2;
  logic [TAG_W-1:0] req_rd;
  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_data;
  logic [TAG_W-1:0] resp_rd;

  mul_pipe #(.TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_rd     (req_rd),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_rd    (resp_rd)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [TAG_W-1:0] rd;
    logic [31:0]      data;
  } exp_t;

  exp_t             exp_q[$];
  logic [TAG_W-1:0] got_rd[$];
  logic             held = 1'b0;
  logic [31:0]      held_data;
  logic [TAG_W-1:0] held_rd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer product of the (sign- or zero-extended) operands.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] p;
    ea = (op == 2'd1 || op == 2'd2) ? {{32{a[31]}}, a} : {32'd0, a};
    eb = (op == 2'd1) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ea * eb;
    return (op == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  // Scoreboard: evaluated mid-cycle on what the next rising edge will sample.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      held = 1'b0;
    end else begin
      if (held) begin
        chk("hold_vld", {63'd0, resp_valid}, 64'd1);
        chk("hold_data", {32'd0, resp_data}, {32'd0, held_data});
        chk("hold_rd", {59'd0, resp_rd}, {59'd0, held_rd});
      end
      chk("req_ready", {63'd0, req_ready},
          {63'd0, !(resp_valid && !resp_ready) && !flush});
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_vld", {63'd0, resp_valid}, 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("resp_data", {32'd0, resp_data}, {32'd0, e.data});
          chk("resp_rd", {59'd0, resp_rd}, {59'd0, e.rd});
          got_rd.push_back(resp_rd);
        end
      end
      held      = resp_valid && !resp_ready && !flush;
      held_data = resp_data;
      held_rd   = resp_rd;
      if (flush) exp_q.delete();
      else if (req_valid && req_ready)
        exp_q.push_back('{rd: req_rd, data: model(req_op, req_rs1, req_rs2)});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] rd);
    req_valid = 1'b1;
    req_op    = op;
    req_rs1   = a;
    req_rs2   = b;
    req_rd    = rd;
  endtask

  // Single op on an idle pipeline; checks the fixed three-cycle latency.
  task automatic one_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [TAG_W-1:0] rd,
                        input logic [31:0] exp);
    set_req(op, a, b, rd);
    @(negedge clk);
    chk({tag, "_acc"}, {63'd0, req_ready}, 64'd1);
    tick();
    req_valid = 1'b0;
    chk({tag, "_lat1"}, {63'd0, resp_valid}, 64'd0);
    tick();
    chk({tag, "_lat2"}, {63'd0, resp_valid}, 64'd0);
    tick();
    chk({tag, "_vld"}, {63'd0, resp_valid}, 64'd1);
    chk({tag, "_data"}, {32'd0, resp_data}, {32'd0, exp});
    chk({tag, "_rd"}, {59'd0, resp_rd}, {59'd0, rd});
    tick();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
    req_op = 2'd0; req_rs1 = '0; req_rs2 = '0; req_rd = '0;
    tick(); tick();
    chk("rst_vld", {63'd0, resp_valid}, 64'd0);
    chk("rst_data", {32'd0, resp_data}, 64'd0);
    chk("rst_rd", {59'd0, resp_rd}, 64'd0);
    rst = 1'b0;
    tick();

    one_op("mul7x6", 2'd0, 32'd7, 32'd6, 5'd3, 32'h0000002A);
    one_op("mul_ff", 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'h00000001);
    one_op("mulh_ff", 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 32'h00000000);
    one_op("mulhsu_ff", 2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6, 32'hFFFFFFFF);
    one_op("mulhu_ff", 2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 32'hFFFFFFFE);
    one_op("mulh_min", 2'd1, 32'h80000000, 32'h80000000, 5'd8, 32'h40000000);
    one_op("mul_min2", 2'd0, 32'h80000000, 32'h00000002, 5'd9, 32'h00000000);
    one_op("mulh_min1", 2'd1, 32'h80000000, 32'h00000001, 5'd10, 32'hFFFFFFFF);

    // Four back-to-back MULs with the consumer stalled for three cycles.
    got_rd.delete();
    set_req(2'd0, 32'd11, 32'd3, 5'd1); tick();
    set_req(2'd0, 32'd12, 32'd3, 5'd2); tick();
    set_req(2'd0, 32'd13, 32'd3, 5'd3); tick();
    set_req(2'd0, 32'd14, 32'd3, 5'd4);
    resp_ready = 1'b0;
    chk("stall_vld", {63'd0, resp_valid}, 64'd1);
    chk("stall_rd_first", {59'd0, resp_rd}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_ready", {63'd0, req_ready}, 64'd0);
      tick();
    end
    chk("stall_rd_held", {59'd0, resp_rd}, 64'd1);
    resp_ready = 1'b1;
    @(negedge clk);
    chk("unstall_ready", {63'd0, req_ready}, 64'd1);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("order_cnt", 64'(got_rd.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      if (i < got_rd.size()) chk("order_rd", {59'd0, got_rd[i]}, 64'(i + 1));

    // Flush with two ops in flight, then a fresh op the next cycle.
    set_req(2'd0, 32'd100, 32'd100, 5'd11); tick();
    set_req(2'd3, 32'd200, 32'd200, 5'd12); tick();
    req_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_vld0", {63'd0, resp_valid}, 64'd0);
    one_op("post_flush", 2'd0, 32'd3, 32'd5, 5'd13, 32'h0000000F);
    for (int i = 0; i < 4; i++) begin
      chk("flush_quiet", {63'd0, resp_valid}, 64'd0);
      tick();
    end

    // Reset with three ops in flight and a result waiting at the output.
    resp_ready = 1'b0;
    set_req(2'd0, 32'd21, 32'd2, 5'd21); tick();
    set_req(2'd0, 32'd22, 32'd2, 5'd22); tick();
    set_req(2'd0, 32'd23, 32'd2, 5'd23); tick();
    req_valid = 1'b0;
    chk("prerst_vld", {63'd0, resp_valid}, 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    resp_ready = 1'b1;
    chk("midrst_vld", {63'd0, resp_valid}, 64'd0);
    chk("midrst_data", {32'd0, resp_data}, 64'd0);
    chk("midrst_rd", {59'd0, resp_rd}, 64'd0);
    @(negedge clk);
    chk("midrst_ready", {63'd0, req_ready}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("midrst_quiet", {63'd0, resp_valid}, 64'd0);
    end

    // Randomized traffic with backpressure and occasional flushes.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      case ($urandom_range(0, 5))
        0: a = 32'h80000000;
        1: a = 32'hFFFFFFFF;
        2: a = 32'd0;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: b = 32'h80000000;
        1: b = 32'hFFFFFFFF;
        2: b = 32'd1;
        default: b = $urandom;
      endcase
      req_valid  = ($urandom_range(0, 9) < 7);
      req_op     = 2'($urandom_range(0, 3));
      req_rs1    = a;
      req_rs2    = b;
      req_rd     = TAG_W'($urandom);
      resp_ready = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 39) == 0);
      tick();
    end
    req_valid = 1'b0; flush = 1'b0; resp_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    chk("drain_vld", {63'd0, resp_valid}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
